// File: rtl/tcdm_target_adapter.sv
// tcdm_target_adapter
//
// Target-side stage that sits directly after one interconnect output port.
// It turns the interconnect's valid/ready request channel into a fixed-latency
// SRAM access. It also returns one response per request, tagged with the
// initiator index, on a valid/ready response channel.
//
// A credit counter limits the number of outstanding requests to the number of
// response FIFO entries. Every accepted request therefore always finds a free
// FIFO slot when its read data arrives, even while the response channel is
// stalled.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   req_valid_i/ready_o   request handshake from the interconnect
//   req_ini_addr_i        initiator index carried through to the response
//   req_tgt_addr_i        word address inside this target
//   req_wen_i             write enable (a write still yields a response)
//   req_wdata_i/be_i      write data and byte enables
//   resp_valid_o/ready_i  response handshake back into the interconnect
//   resp_ini_addr_o       initiator index of the response at the FIFO head
//   resp_rdata_o          read data (zero for write responses)
//   mem_*                 SRAM port; read data returns MemLatency cycles
//                         after mem_req_o
module tcdm_target_adapter #(
    parameter int AddrMemWidth = 12,
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8,
    parameter int IniAddrWidth = 5,
    parameter int MemLatency   = 1,
    parameter int RespDepth    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IniAddrWidth-1:0] req_ini_addr_i,
    input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [BeWidth-1:0]      req_be_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [IniAddrWidth-1:0] resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AddrMemWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    localparam int CreditWidth = $clog2(RespDepth + 1);
    localparam int PtrWidth    = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(RespDepth);
    localparam logic [PtrWidth-1:0]    PtrLast   = PtrWidth'(RespDepth - 1);

    logic [CreditWidth-1:0]  credit_q;
    logic                    accept;
    logic                    pop;
    logic                    push;
    logic [DataWidth-1:0]    push_data;

    logic [MemLatency-1:0]   tag_valid_q;
    logic [MemLatency-1:0]   tag_wen_q;
    logic [IniAddrWidth-1:0] tag_ini_q [MemLatency];

    logic [IniAddrWidth-1:0] fifo_ini_q  [RespDepth];
    logic [DataWidth-1:0]    fifo_data_q [RespDepth];
    logic [PtrWidth-1:0]     wr_ptr_q;
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [CreditWidth-1:0]  count_q;

    // Ready depends only on the credit register, never on req_valid_i.
    assign req_ready_o = (credit_q != '0);
    assign accept      = req_valid_i & req_ready_o;

    // The SRAM never stalls, so an accepted request is issued in the same cycle.
    assign mem_req_o   = accept;
    assign mem_we_o    = req_wen_i;
    assign mem_addr_o  = req_tgt_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_be_i;

    // The last tag stage lines up with the cycle in which mem_rdata_i is valid.
    assign push      = tag_valid_q[MemLatency-1];
    assign push_data = tag_wen_q[MemLatency-1] ? '0 : mem_rdata_i;

    // There is no fall-through: responses are presented only from FIFO storage.
    // The head is gated so that an empty FIFO shows zeros.
    assign resp_valid_o    = (count_q != '0);
    assign pop             = resp_valid_o & resp_ready_i;
    assign resp_ini_addr_o = resp_valid_o ? fifo_ini_q[rd_ptr_q]  : '0;
    assign resp_rdata_o    = resp_valid_o ? fifo_data_q[rd_ptr_q] : '0;

    // One credit is taken on accept and returned on pop. The credit is held
    // from accept until the response leaves, so issuing one request every cycle
    // needs enough credits to cover the full round trip.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q <= CreditMax;
        end else begin
            case ({accept, pop})
                2'b10:   credit_q <= credit_q - CreditWidth'(1);
                2'b01:   credit_q <= credit_q + CreditWidth'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

    // The valid bits of the tag pipeline are reset so that a reset discards
    // every in-flight request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_valid_q <= '0;
        end else begin
            tag_valid_q[0] <= accept;
            for (int i = 1; i < MemLatency; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
            end
        end
    end

    // The tag payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk_i) begin
        tag_ini_q[0] <= req_ini_addr_i;
        tag_wen_q[0] <= req_wen_i;
        for (int i = 1; i < MemLatency; i++) begin
            tag_ini_q[i] <= tag_ini_q[i-1];
            tag_wen_q[i] <= tag_wen_q[i-1];
        end
    end

    // Response FIFO control: pointers wrap at RespDepth. A simultaneous push
    // and pop leaves the occupancy unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CreditWidth'(1);
                2'b01:   count_q <= count_q - CreditWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage is written only on push; stale slots are never presented.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_ini_q[wr_ptr_q]  <= tag_ini_q[MemLatency-1];
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

    // Credit bookkeeping invariants. The credit accounting makes these
    // situations impossible; if one occurs, the counters are inconsistent.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            a_credit_range: assert (credit_q <= CreditMax);
            a_credit_overflow: assert (!(pop && !accept && credit_q == CreditMax));
            a_push_full: assert (!(push && count_q == CreditMax));
        end
    end

endmodule

// File: tb/tb_tcdm_target_adapter.sv
// tb_tcdm_target_adapter
//
// Randomised scoreboard bench for tcdm_target_adapter.
//
// The stimulus side issues requests. It computes each expected response from a
// word-level reference memory and pushes it into a queue. The expected
// response carries the cycle in which it was accepted.
//
// A separate monitor runs every cycle. It checks that resp_valid_o is high
// exactly when the oldest outstanding response has had MemLatency+1 cycles to
// arrive. It compares the head data and initiator index, and it pops the queue
// on each handshake.
//
// Credit behaviour is modelled as "outstanding = accepted - popped; ready
// while outstanding < RespDepth".
module tb_tcdm_target_adapter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int IW = 5;
    localparam int L  = 1;
    localparam int D  = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [IW-1:0] req_ini_addr_i;
    logic [AW-1:0] req_tgt_addr_i;
    logic          req_wen_i;
    logic [DW-1:0] req_wdata_i;
    logic [BW-1:0] req_be_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [IW-1:0] resp_ini_addr_o;
    logic [DW-1:0] resp_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    tcdm_target_adapter #(
        .AddrMemWidth(AW),
        .DataWidth   (DW),
        .BeWidth     (BW),
        .IniAddrWidth(IW),
        .MemLatency  (L),
        .RespDepth   (D)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_ini_addr_i (req_ini_addr_i),
        .req_tgt_addr_i (req_tgt_addr_i),
        .req_wen_i      (req_wen_i),
        .req_wdata_i    (req_wdata_i),
        .req_be_i       (req_be_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_ini_addr_o(resp_ini_addr_o),
        .resp_rdata_o   (resp_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    typedef struct {
        logic [IW-1:0] ini;
        logic [DW-1:0] rdata;
        int            cycle;
    } exp_t;

    exp_t          exp_q[$];
    bit [DW-1:0]   ref_mem [int];
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            cyc          = 0;
    int            accepted     = 0;
    int            popped       = 0;
    bit            checking     = 1'b0;

    // Power-on memory contents, shared by the SRAM model and the reference.
    function automatic bit [DW-1:0] init_word(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return (32'h9E3779B1 * a) ^ 32'h0F0F1234;
    endfunction

    function automatic bit [DW-1:0] merge_bytes(input bit [DW-1:0] old_w,
                                                input bit [DW-1:0] new_w,
                                                input bit [BW-1:0] be);
        bit [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural SRAM with MemLatency read latency, driven by the DUT's mem port.
    bit [DW-1:0] sram [1<<AW];
    bit          sram_written [1<<AW];
    logic [DW-1:0] rd_pipe [L];

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                sram[mem_addr_o] <= merge_bytes(sram_written[mem_addr_o] ? sram[mem_addr_o]
                                                : init_word(int'(mem_addr_o)),
                                                mem_wdata_o, mem_be_o);
                sram_written[mem_addr_o] <= 1'b1;
            end
            rd_pipe[0] <= sram_written[mem_addr_o] ? sram[mem_addr_o]
                                                   : init_word(int'(mem_addr_o));
        end else begin
            rd_pipe[0] <= $urandom;
        end
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rdata_i = rd_pipe[L-1];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of request/response-ready stimulus. Check the handshake
    // and the SRAM pass-through, and record the expected response of an
    // accepted request.
    task automatic applyStimulus(input bit valid, input logic [IW-1:0] ini,
                                 input logic [AW-1:0] addr, input bit wen,
                                 input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                                 input bit rready, output bit acc);
        bit          exp_ready;
        bit [DW-1:0] cur;
        exp_t        e;
        @(negedge clk_i);
        rst_i          = 1'b0;
        req_valid_i    = valid;
        req_ini_addr_i = ini;
        req_tgt_addr_i = addr;
        req_wen_i      = wen;
        req_wdata_i    = wdata;
        req_be_i       = be;
        resp_ready_i   = rready;
        #1;
        exp_ready = (accepted - popped) < D;
        checkOutput("req_ready", 64'(req_ready_o), 64'(exp_ready));
        acc = valid && req_ready_o;
        checkOutput("mem_req", 64'(mem_req_o), 64'(acc));
        if (acc) begin
            checkOutput("mem_we", 64'(mem_we_o), 64'(wen));
            checkOutput("mem_addr", 64'(mem_addr_o), 64'(addr));
            checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(wdata));
            checkOutput("mem_be", 64'(mem_be_o), 64'(be));
            cur = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : init_word(int'(addr));
            e.ini   = ini;
            e.cycle = cyc;
            if (wen) begin
                e.rdata = '0;
                ref_mem[int'(addr)] = merge_bytes(cur, wdata, be);
            end else begin
                e.rdata = cur;
            end
            exp_q.push_back(e);
            accepted++;
        end
    endtask

    task automatic idle(input bit rready);
        bit a;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, rready, a);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic applyReset(input int n);
        @(negedge clk_i);
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b0;
        exp_q.delete();
        accepted = 0;
        popped   = 0;
        repeat (n) @(posedge clk_i);
    endtask

    task automatic checkReset();
        #2;
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'(1));
        checkOutput("rst_mem_req", 64'(mem_req_o), 64'(0));
        checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'(0));
        checkOutput("rst_resp_ini", 64'(resp_ini_addr_o), 64'(0));
        checkOutput("rst_resp_rdata", 64'(resp_rdata_o), 64'(0));
    endtask

    // Monitor: the response at the head of the queue must be visible exactly
    // from accept cycle + MemLatency + 1. It must stay stable while it is held,
    // and it leaves the queue on a handshake.
    initial begin
        bit exp_valid;
        forever begin
            @(negedge clk_i);
            #2;
            if (checking && !rst_i) begin
                exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].cycle + L + 1);
                checkOutput("resp_valid", 64'(resp_valid_o), 64'(exp_valid));
                if (resp_valid_o && exp_q.size() > 0) begin
                    checkOutput("resp_ini", 64'(resp_ini_addr_o), 64'(exp_q[0].ini));
                    checkOutput("resp_rdata", 64'(resp_rdata_o), 64'(exp_q[0].rdata));
                    if (resp_ready_i) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end else if (resp_valid_o && resp_ready_i) begin
                    popped++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int n_acc;
        int tries;
        rst_i          = 1'b1;
        req_valid_i    = 1'b0;
        req_ini_addr_i = '0;
        req_tgt_addr_i = '0;
        req_wen_i      = 1'b0;
        req_wdata_i    = '0;
        req_be_i       = '0;
        resp_ready_i   = 1'b0;

        applyReset(2);
        checkReset();
        checking = 1'b1;

        // Single read right after reset release.
        applyStimulus(1'b1, 5'd3, 12'h010, 1'b0, '0, '0, 1'b1, acc);
        checkOutput("t1_accept", 64'(acc), 64'(1));
        drain();

        // Back-to-back reads, each offered until accepted.
        for (int i = 0; i < 16; i++) begin
            tries = 0;
            do begin
                applyStimulus(1'b1, IW'(i), AW'($urandom_range(0, 63)), 1'b0,
                              '0, '0, 1'b1, acc);
                tries++;
            end while (!acc && tries < 8);
            checkOutput("stream_accept", 64'(acc), 64'(1));
        end
        drain();

        // Backpressure: only RespDepth requests fit while responses are held.
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, IW'(10 + i), AW'(i), 1'b0, '0, '0, 1'b0, acc);
            if (acc) n_acc++;
        end
        checkOutput("t3_accepted", 64'(n_acc), 64'(2));
        idle(1'b1);
        applyStimulus(1'b1, 5'd20, 12'h005, 1'b0, '0, '0, 1'b0, acc);
        checkOutput("t3_reaccept", 64'(acc), 64'(1));
        drain();

        // Partial write, then read back the merged word.
        applyStimulus(1'b1, 5'd7, 12'h020, 1'b1, 32'h12345678, 4'b0011, 1'b1, acc);
        checkOutput("t4_accept", 64'(acc), 64'(1));
        applyStimulus(1'b1, 5'd8, 12'h020, 1'b0, '0, '0, 1'b1, acc);
        drain();

        // Accept and pop together with one FIFO entry, then hold the new head.
        applyStimulus(1'b1, 5'd1, 12'h003, 1'b0, '0, '0, 1'b0, acc);
        idle(1'b0);
        idle(1'b0);
        applyStimulus(1'b1, 5'd2, 12'h004, 1'b0, '0, '0, 1'b1, acc);
        checkOutput("t5_accept", 64'(acc), 64'(1));
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        drain();

        // Random traffic over a small address window so reads hit earlier writes.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), IW'($urandom_range(0, 31)),
                          AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          DW'($urandom), BW'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0), acc);
        end
        drain();

        // Reset with two requests in flight; nothing stale may appear afterwards.
        applyStimulus(1'b1, 5'd11, 12'h001, 1'b0, '0, '0, 1'b0, acc);
        applyStimulus(1'b1, 5'd12, 12'h002, 1'b0, '0, '0, 1'b0, acc);
        applyReset(1);
        checkReset();
        for (int i = 0; i < 10; i++) idle(1'b1);
        applyStimulus(1'b1, 5'd13, 12'h010, 1'b0, '0, '0, 1'b1, acc);
        checkOutput("t6_accept", 64'(acc), 64'(1));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
